fp_accum: RTL and testbench

FP_ACCUM -- requirements
Module: fp_accum

---
 rtl/fp_accum_pkg.sv | 18 +
 rtl/fp_lzc.sv | 21 ++
 rtl/fp_accum.sv | 218 +++++++++++++++++++++
 tb/tb_fp_accum.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fp_accum_pkg.sv
// Shared types and constants for the single-precision accumulator.
package fp_accum_pkg;

   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned BIAS  = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK} state_t;

   // Subnormals (and signed zeros) become +0 before they reach the datapath.
   function automatic logic [31:0] flush_sub(input logic [31:0] x);
      return (x[EXP_W+MAN_W-1:MAN_W] == '0) ? 32'h0 : x;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; count == W when value is all zeros.
import fp_accum_pkg::*;

module fp_lzc #(
   parameter int unsigned W = 28
) (
   input  logic [W-1:0]           value,
   output logic [$clog2(W+1)-1:0] count
);

   localparam int unsigned CW = $clog2(W + 1);

   // Highest set bit wins because later loop iterations overwrite earlier ones.
   always_comb begin
      count = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (value[i]) count = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/fp_accum.sv
// Pipelined-FSM single-precision accumulator (IDLE/ALIGN/ADD/NORM/PACK).
// Optional macro FP_ACCUM_RNE_EN selects round-to-nearest-even in PACK;
// without it PACK truncates toward zero.
import fp_accum_pkg::*;

module fp_accum #(
   parameter int unsigned GUARD_BITS = 3  // must be >= 2 (guard, round/sticky)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        clear,
   output logic [31:0] acc_out,
   output logic        done,
   output logic        ovf,
   output logic        nan
);

   localparam int unsigned SW  = 24 + GUARD_BITS;
   localparam int unsigned LZW = $clog2(SW + 2);
   localparam logic signed [9:0] EXP_INF = 10'(2 * BIAS + 1);

   state_t state;
   logic [31:0] a_q, b_q, sp_val_q, acc_q;
   logic sp_q, sp_nan_q, sign_q, sub_q, zero_q, done_q, ovf_q, nan_q;
   logic signed [9:0] exp_q;
   logic [SW-1:0] big_q, sml_q, norm_q;
   logic [SW:0] sum_q;

   logic accept;
   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;
   assign acc_out  = acc_q;
   assign done     = done_q;
   assign ovf      = ovf_q;
   assign nan      = nan_q;

   // ALIGN: special-value decode and right shift of the smaller operand with sticky.
   logic [7:0] a_exp, b_exp, exp_diff;
   logic [23:0] a_sig, b_sig;
   logic a_is_nan, a_is_inf, b_is_nan, b_is_inf, a_big, sp_hit, sp_nan;
   logic [31:0] sp_val;
   logic [SW-1:0] sml_ext, shifted, lost_mask;
   always_comb begin
      a_exp    = a_q[EXP_W+MAN_W-1:MAN_W];
      b_exp    = b_q[EXP_W+MAN_W-1:MAN_W];
      a_sig    = (a_exp == 8'd0) ? 24'd0 : {1'b1, a_q[MAN_W-1:0]};
      b_sig    = (b_exp == 8'd0) ? 24'd0 : {1'b1, b_q[MAN_W-1:0]};
      a_is_nan = (&a_exp) && (|a_q[MAN_W-1:0]);
      a_is_inf = (&a_exp) && !(|a_q[MAN_W-1:0]);
      b_is_nan = (&b_exp) && (|b_q[MAN_W-1:0]);
      b_is_inf = (&b_exp) && !(|b_q[MAN_W-1:0]);
      a_big    = a_q[30:0] > b_q[30:0];
      sp_hit   = 1'b0;
      sp_nan   = 1'b0;
      sp_val   = b_q;
      if (a_is_nan || b_is_nan || (a_is_inf && b_is_inf && (a_q[31] != b_q[31]))) begin
         sp_hit = 1'b1;
         sp_nan = 1'b1;
         sp_val = QNAN;
      end else if (b_is_inf) begin
         sp_hit = 1'b1;  // finite + inf accumulator keeps the accumulator
      end else if (a_is_inf) begin
         sp_hit = 1'b1;
         sp_val = a_q;
      end
      exp_diff  = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
      sml_ext   = {(a_big ? b_sig : a_sig), {GUARD_BITS{1'b0}}};
      lost_mask = ~({SW{1'b1}} << exp_diff);
      if (32'(exp_diff) >= SW) begin
         shifted = {{(SW-1){1'b0}}, |sml_ext};
      end else begin
         shifted    = sml_ext >> exp_diff;
         shifted[0] = shifted[0] | (|(sml_ext & lost_mask));
      end
   end

   // ADD: magnitudes are ordered, so subtraction never goes negative.
   logic [SW:0] sum;
   always_comb begin
      sum = sub_q ? ({1'b0, big_q} - {1'b0, sml_q}) : ({1'b0, big_q} + {1'b0, sml_q});
   end

   // NORM: carry-out shifts right, otherwise shift left so the hidden bit lands at SW-1.
   logic [LZW-1:0] lz, lz_m1;
   logic [SW:0] shl;
   logic [SW-1:0] norm;
   logic signed [9:0] norm_exp;
   fp_lzc #(.W(SW + 1)) u_lzc (.value(sum_q), .count(lz));
   always_comb begin
      lz_m1 = lz - 1'b1;
      shl   = sum_q << lz_m1;
      if (sum_q[SW]) begin
         norm     = sum_q[SW:1] | {{(SW-1){1'b0}}, sum_q[0]};
         norm_exp = exp_q + 10'sd1;
      end else begin
         norm     = shl[SW-1:0];
         norm_exp = exp_q - 10'(lz_m1);
      end
   end

   // PACK: optional rounding, then zero/overflow handling and field assembly.
   logic [23:0] man;
   logic signed [9:0] exp_r;
   logic [31:0] pack_res;
   logic pack_ovf, unused_bits;
`ifdef FP_ACCUM_RNE_EN
   logic g_bit, st_bit, up;
   logic [24:0] rnd;
`endif
   always_comb begin
      man   = norm_q[SW-1:GUARD_BITS];
      exp_r = exp_q;
`ifdef FP_ACCUM_RNE_EN
      g_bit  = norm_q[GUARD_BITS-1];
      st_bit = |norm_q[GUARD_BITS-2:0];
      up     = g_bit && (st_bit || man[0]);
      rnd    = {1'b0, man} + {24'd0, up};
      if (rnd[24]) begin
         man   = 24'h80_0000;
         exp_r = exp_q + 10'sd1;
      end else begin
         man = rnd[23:0];
      end
      unused_bits = man[23];
`else
      unused_bits = man[23] ^ (^norm_q[GUARD_BITS-1:0]);
`endif
      pack_ovf = 1'b0;
      if (zero_q || (exp_r <= 10'sd0)) begin
         pack_res = 32'h0;
      end else if (exp_r >= EXP_INF) begin
         pack_res = {sign_q, POS_INF[30:0]};
         pack_ovf = 1'b1;
      end else begin
         pack_res = {sign_q, exp_r[7:0], man[MAN_W-1:0]};
      end
   end

   // Sequencer and all datapath/output registers; clear outside IDLE aborts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sp_val_q <= '0;
         acc_q    <= '0;
         sp_q     <= 1'b0;
         sp_nan_q <= 1'b0;
         sign_q   <= 1'b0;
         sub_q    <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         nan_q    <= 1'b0;
         exp_q    <= '0;
         big_q    <= '0;
         sml_q    <= '0;
         norm_q   <= '0;
         sum_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (clear) begin
                  acc_q <= '0;
                  ovf_q <= 1'b0;
                  nan_q <= 1'b0;
               end
               if (accept) begin
                  a_q   <= flush_sub(in_data);
                  b_q   <= clear ? 32'h0 : acc_q;
                  state <= ALIGN;
               end
            end
            ALIGN: begin
               sp_q     <= sp_hit;
               sp_nan_q <= sp_nan;
               sp_val_q <= sp_val;
               sign_q   <= a_big ? a_q[31] : b_q[31];
               sub_q    <= a_q[31] ^ b_q[31];
               exp_q    <= {2'b00, (a_big ? a_exp : b_exp)};
               big_q    <= {(a_big ? a_sig : b_sig), {GUARD_BITS{1'b0}}};
               sml_q    <= shifted;
               state    <= ADD;
            end
            ADD: begin
               sum_q <= sum;
               state <= NORM;
            end
            NORM: begin
               norm_q <= norm;
               exp_q  <= norm_exp;
               zero_q <= ~|sum_q;
               state  <= PACK;
            end
            PACK: begin
               acc_q  <= sp_q ? sp_val_q : pack_res;
               nan_q  <= nan_q | sp_nan_q;
               ovf_q  <= ovf_q | (!sp_q && pack_ovf);
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (clear && (state != IDLE)) begin
            state  <= IDLE;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            nan_q  <= 1'b0;
            done_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fp_accum.sv
// Directed self-checking bench for fp_accum (honours FP_ACCUM_RNE_EN if defined).
module tb_fp_accum;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, clear, done, ovf, nan;
   logic [31:0] in_data, acc_out;
   int passed = 0;
   int total  = 0;
   logic seen_done;

   fp_accum #(.GUARD_BITS(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .clear    (clear),
      .acc_out  (acc_out),
      .done     (done),
      .ovf      (ovf),
      .nan      (nan)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask

   // Accept one operand (caller sits just after a rising edge with the block idle),
   // then require done to stay low for 3 edges and pulse on the 4th.
   task automatic do_op(input logic [31:0] data, input logic clr, input string tag);
      logic early;
      in_data  = data;
      in_valid = 1'b1;
      clear    = clr;
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      clear    = 1'b0;
      early    = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         early = early | done;
      end
      @(posedge clk); #1;
      check({tag, "_done"}, {30'd0, early, done}, 32'd1);
   endtask

   task automatic clear_only(input string tag);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check({tag, "_nodone"}, 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      clear    = 1'b0;
      in_data  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_acc", acc_out, 32'h0);
      check("rst_flags", {29'd0, done, ovf, nan}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // 1.0 + 1.0
      clear_only("clr0");
      check("clr0_acc", acc_out, 32'h0);
      do_op(32'h3F80_0000, 1'b0, "one_a");
      check("one_a_acc", acc_out, 32'h3F80_0000);
      do_op(32'h3F80_0000, 1'b0, "one_b");
      check("two_acc", acc_out, 32'h4000_0000);

      // subnormal input flushes; clear with accept loads it as the new sum
      do_op(32'h0040_0000, 1'b1, "subn");
      check("subn_acc", acc_out, 32'h0);

      // exact cancellation
      do_op(32'h3F80_0000, 1'b1, "canc_a");
      do_op(32'hBF80_0000, 1'b0, "canc_b");
      check("canc_acc", acc_out, 32'h0);

      // subtraction with renormalisation: 1.0 - 0.25 = 0.75
      do_op(32'h3F80_0000, 1'b1, "sub_a");
      do_op(32'hBE80_0000, 1'b0, "sub_b");
      check("sub_acc", acc_out, 32'h3F40_0000);

      // negative result: 0.5 - 2.0 = -1.5
      do_op(32'h3F00_0000, 1'b1, "neg_a");
      do_op(32'hC000_0000, 1'b0, "neg_b");
      check("neg_acc", acc_out, 32'hBFC0_0000);

      // inf - inf -> NaN, sticky until clear
      do_op(32'h7F80_0000, 1'b1, "inf_a");
      check("inf_acc", acc_out, 32'h7F80_0000);
      do_op(32'h3F80_0000, 1'b0, "inf_fin");
      check("inf_keep", acc_out, 32'h7F80_0000);
      do_op(32'hFF80_0000, 1'b0, "inf_b");
      check("nan_acc", acc_out, 32'h7FC0_0000);
      check("nan_flag", 32'(nan), 32'd1);
      do_op(32'h3F80_0000, 1'b0, "nan_more");
      check("nan_stick", acc_out, 32'h7FC0_0000);
      clear_only("nan_clr");
      check("nan_clr_acc", acc_out, 32'h0);
      check("nan_clr_flag", 32'(nan), 32'd0);

      // overflow to infinity
      do_op(32'h7F7F_FFFF, 1'b1, "ovf_a");
      check("ovf_a_flag", 32'(ovf), 32'd0);
      do_op(32'h7F7F_FFFF, 1'b0, "ovf_b");
      check("ovf_acc", acc_out, 32'h7F80_0000);
      check("ovf_flag", 32'(ovf), 32'd1);
      clear_only("ovf_clr");
      check("ovf_clr_flag", 32'(ovf), 32'd0);

      // rounding of 1.0 + (2^-24 * 1.00000012)
      do_op(32'h3F80_0000, 1'b1, "rnd_a");
      do_op(32'h3380_0001, 1'b0, "rnd_b");
`ifdef FP_ACCUM_RNE_EN
      check("rnd_acc", acc_out, 32'h3F80_0001);
`else
      check("rnd_acc", acc_out, 32'h3F80_0000);
`endif

      // clear during ALIGN aborts the second operation
      in_data  = 32'h3F80_0000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      clear    = 1'b1;
      @(posedge clk); #1;
      clear     = 1'b0;
      seen_done = done;
      repeat (5) begin
         @(posedge clk); #1;
         seen_done = seen_done | done;
      end
      check("abort_nodone", 32'(seen_done), 32'd0);
      check("abort_acc", acc_out, 32'h0);
      check("abort_ready", 32'(in_ready), 32'd1);

      // reset mid-operation discards it
      do_op(32'h3F80_0000, 1'b0, "mr_a");
      check("mr_a_acc", acc_out, 32'h3F80_0000);
      in_data  = 32'h3F80_0000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("mr_async_acc", acc_out, 32'h0);
      check("mr_async_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst       = 1'b0;
      seen_done = done;
      repeat (5) begin
         @(posedge clk); #1;
         seen_done = seen_done | done;
      end
      check("mr_nodone", 32'(seen_done), 32'd0);
      check("mr_acc", acc_out, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
